// File: rtl/pac_pkg.sv
// Shared ghost-direction types and helpers used by the frightened and chase
// direction selectors.
package pac_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    function automatic dir_t reverse(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

    function automatic logic [3:0] onehot(input dir_t d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/ghost_dir_mask.sv
// Candidate-move mask (legal moves minus reversal, unless that leaves nothing)
// and its fixed-priority pick in UP, LEFT, DOWN, RIGHT order.
module ghost_dir_mask
    import pac_pkg::*;
(
    input  logic [3:0] legal_i,
    input  dir_t       cur_dir_i,
    output logic [3:0] mask_o,
    output dir_t       pick_o
);

    logic [3:0] trimmed;

    always_comb begin
        trimmed = legal_i & ~onehot(reverse(cur_dir_i));
        // Dead end: turning back is the only way out.
        mask_o  = (trimmed == 4'b0000) ? legal_i : trimmed;

        if (mask_o[0])      pick_o = DIR_UP;
        else if (mask_o[1]) pick_o = DIR_LEFT;
        else if (mask_o[2]) pick_o = DIR_DOWN;
        else if (mask_o[3]) pick_o = DIR_RIGHT;
        else                pick_o = DIR_UP;
    end

endmodule

// File: rtl/ghost_dir_select.sv
// Frightened-ghost direction picker: rejection-samples LFSR draws against the
// candidate mask, falling back to the priority pick after MAX_TRIES misses.
module ghost_dir_select
    import pac_pkg::*;
#(
    parameter int MAX_TRIES = 3,
    parameter int TRY_W     = 4
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       req,
    input  logic [1:0] cur_dir,
    input  logic [3:0] legal,
    input  logic [3:0] rand_val,
    output logic       rand_en,
    output logic [1:0] dir_out,
    output logic       dir_valid,
    output logic       busy,
    output logic       fallback
);

    // Handshake: req is a one-cycle pulse honoured only in IDLE; dir_valid is a
    // one-cycle pulse with dir_out/fallback stable from that cycle onwards.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       mask_q, mask_d;
    dir_t             pick_q, pick_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    dir_t             dir_q, dir_d;
    logic             fb_q, fb_d;

    logic [3:0]       mask_w;
    dir_t             pick_w;
    dir_t             draw;
    logic [TRY_W-1:0] tries_inc;
    logic             unused_rand_hi;

    assign unused_rand_hi = ^rand_val[3:2];
    assign draw           = dir_t'(rand_val[1:0]);
    assign tries_inc      = tries_q + 1'b1;

    ghost_dir_mask u_mask (
        .legal_i   (legal),
        .cur_dir_i (dir_t'(cur_dir)),
        .mask_o    (mask_w),
        .pick_o    (pick_w)
    );

    always_ff @(posedge frame_clk) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            mask_q  <= '0;
            pick_q  <= DIR_UP;
            tries_q <= '0;
            dir_q   <= DIR_UP;
            fb_q    <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            pick_q  <= pick_d;
            tries_q <= tries_d;
            dir_q   <= dir_d;
            fb_q    <= fb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        pick_d  = pick_q;
        tries_d = tries_q;
        dir_d   = dir_q;
        fb_d    = fb_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    mask_d  = mask_w;
                    pick_d  = pick_w;
                    tries_d = '0;
                    if (legal == 4'b0000) begin
                        dir_d   = dir_t'(cur_dir);
                        fb_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: state_d = S_EVAL;
            S_EVAL: begin
                if (mask_q[draw]) begin
                    dir_d   = draw;
                    fb_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    tries_d = tries_inc;
                    if (tries_inc == TRY_W'(MAX_TRIES)) begin
                        dir_d   = pick_q;
                        fb_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rand_en   = (state_q == S_STEP);
        dir_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        dir_out   = dir_q;
        fallback  = fb_q;
    end

endmodule
